noc_local_ni: RTL and testbench

- Local network interface on the router's P (processor) port.
- Packetizes core message words into head/body/tail flits and drives them into the router's P input using the req/ack link protocol.
- Accepts flits from the router's P output, checks the destination against the node coordinates, strips headers, and buffers payload for the core.
- One instance per mesh node; lx/ly are shared with the co-located router.

---
 rtl/noc_pkg.sv | 38 +++
 rtl/ni_rx_fifo.sv | 45 ++++
 rtl/noc_local_ni.sv | 187 ++++++++++++++++++
 tb/tb_noc_local_ni.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, head field placement and NI FSM state encodings.
package noc_pkg;

  localparam int NOC_FLIT_LENGTH = 16;
  localparam int COORD_W         = 3;

  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_HEAD = 2'b01,
    FT_TAIL = 2'b10,
    FT_RSVD = 2'b11
  } flit_type_e;

  // Head field MSB positions, counted down from FLIT_LENGTH (field MSB = FLIT_LENGTH - offset).
  localparam int HD_DST_X = 3;
  localparam int HD_DST_Y = 6;
  localparam int HD_SRC_X = 9;
  localparam int HD_SRC_Y = 12;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_HEAD      = 2'd1,
    TX_BODY      = 2'd2,
    TX_TAIL_WAIT = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_ACCEPT = 2'd1,
    RX_DROP   = 2'd2
  } rx_state_e;

  function automatic logic coord_match(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                       input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    return (ax == bx) && (ay == by);
  endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// Synchronous RX payload FIFO; pointers carry an extra wrap bit to tell full from empty.
module ni_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written, so push-while-full is safe then.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface on the router P port: packetizes core words into flits (TX)
// and filters/unpacks flits addressed to this node into a payload FIFO (RX).
module noc_local_ni
  import noc_pkg::*;
#(
  parameter int FLIT_LENGTH = NOC_FLIT_LENGTH,
  parameter int RX_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COORD_W-1:0]     lx,
  input  logic [COORD_W-1:0]     ly,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [FLIT_LENGTH-3:0] tx_data,
  input  logic                   tx_last,
  input  logic [COORD_W-1:0]     tx_dst_x,
  input  logic [COORD_W-1:0]     tx_dst_y,
  output logic [FLIT_LENGTH-1:0] net_dataout,
  output logic                   net_reqout,
  input  logic                   net_ackin,
  input  logic [FLIT_LENGTH-1:0] net_datain,
  input  logic                   net_reqin,
  output logic                   net_ackout,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [FLIT_LENGTH-3:0] rx_data,
  output logic                   rx_last,
  output logic [COORD_W-1:0]     rx_src_x,
  output logic [COORD_W-1:0]     rx_src_y,
  output logic                   rx_err
);

  localparam int PW = FLIT_LENGTH - 2;
  localparam int EW = PW + 1 + 2 * COORD_W;

  // Handshakes: core side moves a word on a rising edge with valid & ready both high;
  // link side moves a flit on a rising edge with req & ack both high, the sender holding
  // req/data stable until then and the receiver free to drive ack regardless of req.

  // ---------------- TX ----------------
  tx_state_e        tx_state;
  logic             tx_xfer;
  logic [FLIT_LENGTH-1:0] head_flit;
  logic [FLIT_LENGTH-1:0] data_flit;

  assign tx_xfer  = net_reqout & net_ackin;
  assign tx_ready = (tx_state == TX_BODY) & (~net_reqout | net_ackin);

  always_comb begin
    head_flit = '0;
    head_flit[FLIT_LENGTH-1 -: 2]              = FT_HEAD;
    head_flit[FLIT_LENGTH-HD_DST_X -: COORD_W] = tx_dst_x;
    head_flit[FLIT_LENGTH-HD_DST_Y -: COORD_W] = tx_dst_y;
    head_flit[FLIT_LENGTH-HD_SRC_X -: COORD_W] = lx;
    head_flit[FLIT_LENGTH-HD_SRC_Y -: COORD_W] = ly;
    data_flit = {(tx_last ? FT_TAIL : FT_BODY), tx_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      net_reqout  <= 1'b0;
      net_dataout <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            net_dataout <= head_flit;
            net_reqout  <= 1'b1;
            tx_state    <= TX_HEAD;
          end
        end
        TX_HEAD: begin
          if (tx_xfer) begin
            net_reqout <= 1'b0;
            tx_state   <= TX_BODY;
          end
        end
        TX_BODY: begin
          // Reloading on the transfer edge keeps req high across consecutive flits.
          if (tx_valid && tx_ready) begin
            net_dataout <= data_flit;
            net_reqout  <= 1'b1;
            if (tx_last) tx_state <= TX_TAIL_WAIT;
          end else if (tx_xfer) begin
            net_reqout <= 1'b0;
          end
        end
        TX_TAIL_WAIT: begin
          if (tx_xfer) begin
            net_reqout <= 1'b0;
            tx_state   <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  rx_state_e        rx_state;
  flit_type_e       rx_type;
  logic             rx_live;
  logic             rx_xfer;
  logic             dst_match;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [COORD_W-1:0] pkt_src_x;
  logic [COORD_W-1:0] pkt_src_y;
  logic [EW-1:0]    fifo_wdata;
  logic [EW-1:0]    fifo_rdata;

  assign rx_type   = flit_type_e'(net_datain[FLIT_LENGTH-1 -: 2]);
  assign dst_match = coord_match(net_datain[FLIT_LENGTH-HD_DST_X -: COORD_W],
                                 net_datain[FLIT_LENGTH-HD_DST_Y -: COORD_W], lx, ly);

  // rx_live holds ack low for the cycle right after reset.
  assign net_ackout = rx_live & ((rx_state == RX_DROP) | ~fifo_full);
  assign rx_xfer    = net_reqin & net_ackout;
  assign fifo_push  = rx_xfer & (rx_state == RX_ACCEPT) & ((rx_type == FT_BODY) | (rx_type == FT_TAIL));
  assign fifo_wdata = {pkt_src_x, pkt_src_y, (rx_type == FT_TAIL), net_datain[PW-1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      rx_live   <= 1'b0;
      rx_err    <= 1'b0;
      pkt_src_x <= '0;
      pkt_src_y <= '0;
    end else begin
      rx_live <= 1'b1;
      rx_err  <= 1'b0;
      if (rx_xfer) begin
        case (rx_state)
          RX_IDLE: begin
            if (rx_type == FT_HEAD) begin
              if (dst_match) begin
                pkt_src_x <= net_datain[FLIT_LENGTH-HD_SRC_X -: COORD_W];
                pkt_src_y <= net_datain[FLIT_LENGTH-HD_SRC_Y -: COORD_W];
                rx_state  <= RX_ACCEPT;
              end else begin
                rx_err   <= 1'b1;
                rx_state <= RX_DROP;
              end
            end else begin
              rx_err <= 1'b1;
            end
          end
          RX_ACCEPT: begin
            case (rx_type)
              FT_BODY: ;
              FT_TAIL: rx_state <= RX_IDLE;
              default: begin
                rx_err   <= 1'b1;
                rx_state <= RX_DROP;
              end
            endcase
          end
          RX_DROP: begin
            if ((rx_type == FT_TAIL) || (rx_type == FT_RSVD)) rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  ni_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (EW)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (rx_valid & rx_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign {rx_src_x, rx_src_y, rx_last, rx_data} = fifo_rdata;

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni: TX packetizing, link stalls, RX filtering, FIFO backpressure, reset.
module tb_noc_local_ni;
  import noc_pkg::*;

  localparam int F  = 16;
  localparam int PW = F - 2;
  localparam int EW = PW + 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    lx = 3'd2, ly = 3'd1;
  logic          tx_valid = 1'b0, tx_ready, tx_last = 1'b0;
  logic [PW-1:0] tx_data = '0;
  logic [2:0]    tx_dst_x = '0, tx_dst_y = '0;
  logic [F-1:0]  net_dataout, net_datain = '0;
  logic          net_reqout, net_ackin = 1'b1, net_reqin = 1'b0, net_ackout;
  logic          rx_valid, rx_ready = 1'b1, rx_last, rx_err;
  logic [PW-1:0] rx_data;
  logic [2:0]    rx_src_x, rx_src_y;

  int checks = 0;
  int errors = 0;

  logic [F-1:0]  tx_q[$];
  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] msg[8];

  int   ack_mode = 0;
  int   ack_wait = 0;
  int   req_cycles = 0;
  int   err_cnt = 0;
  logic tx_acc = 1'b0;
  logic rx_xfer_seen = 1'b0;
  logic prev_stall = 1'b0;
  logic [F-1:0] prev_data = '0;

  noc_local_ni #(.FLIT_LENGTH(F), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .lx(lx), .ly(ly),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
    .net_dataout(net_dataout), .net_reqout(net_reqout), .net_ackin(net_ackin),
    .net_datain(net_datain), .net_reqin(net_reqin), .net_ackout(net_ackout),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
    .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [F-1:0] build_head(input logic [2:0] dx, input logic [2:0] dy,
                                               input logic [2:0] sx, input logic [2:0] sy);
    logic [F-1:0] h;
    h = '0;
    h[15:14] = 2'b01;
    h[13:11] = dx;
    h[10:8]  = dy;
    h[7:5]   = sx;
    h[4:2]   = sy;
    return h;
  endfunction

  // Samples at the falling edge; scores TX flits and RX words against the queues.
  task automatic monitor();
    tx_acc       = tx_valid & tx_ready;
    rx_xfer_seen = net_reqin & net_ackout;
    if (rx_err) err_cnt++;
    if (net_reqout) req_cycles++;
    if (prev_stall) begin
      check("tx_hold_req", {31'b0, net_reqout}, 32'd1);
      check("tx_hold_data", {16'b0, net_dataout}, {16'b0, prev_data});
    end
    if (net_reqout && !net_ackin) check("tx_ready_stall", {31'b0, tx_ready}, 32'd0);
    if (net_reqout && net_ackin) begin
      check("tx_flit_expected", {31'b0, tx_q.size() != 0}, 32'd1);
      if (tx_q.size() != 0) check("tx_flit", {16'b0, net_dataout}, {16'b0, tx_q.pop_front()});
    end
    prev_stall = net_reqout & ~net_ackin;
    prev_data  = net_dataout;
    if (rx_valid && rx_ready) begin
      check("rx_word_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0)
        check("rx_word", {11'b0, rx_src_x, rx_src_y, rx_last, rx_data}, {11'b0, exp_q.pop_front()});
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    case (ack_mode)
      0: net_ackin = 1'b1;
      1: begin
        if (net_reqout && ack_wait < 5) begin
          net_ackin = 1'b0;
          ack_wait++;
        end else begin
          net_ackin = net_reqout;
          ack_wait  = 0;
        end
      end
      default: net_ackin = 1'b0;
    endcase
  endtask

  task automatic send_msg(input logic [2:0] dx, input logic [2:0] dy, input int n);
    int idx = 0;
    int g = 0;
    tx_q.push_back(build_head(dx, dy, lx, ly));
    for (int i = 0; i < n; i++) tx_q.push_back({((i == n - 1) ? 2'b10 : 2'b00), msg[i]});
    req_cycles = 0;
    tx_dst_x = dx;
    tx_dst_y = dy;
    while (idx < n && g < 400) begin
      tx_valid = 1'b1;
      tx_data  = msg[idx];
      tx_last  = (idx == n - 1);
      step();
      g++;
      if (tx_acc) idx++;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    while (tx_q.size() != 0 && g < 400) begin
      step();
      g++;
    end
    check("tx_done_in_time", {31'b0, g < 400}, 32'd1);
    check("tx_q_drained", tx_q.size(), 32'd0);
  endtask

  task automatic put_flit(input logic [F-1:0] f);
    int g = 0;
    net_reqin  = 1'b1;
    net_datain = f;
    do begin
      step();
      g++;
    end while (!rx_xfer_seen && g < 200);
    check("rx_flit_acked", {31'b0, rx_xfer_seen}, 32'd1);
    net_reqin = 1'b0;
  endtask

  task automatic drain_rx();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      step();
      g++;
    end
    step();
    check("rx_q_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_reqout", {31'b0, net_reqout}, 32'd0);
    check("rst_dataout", {16'b0, net_dataout}, 32'd0);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    check("rst_ackout", {31'b0, net_ackout}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_err", {31'b0, rx_err}, 32'd0);
    check("rst_tx_state", {30'b0, dut.tx_state}, {30'b0, TX_IDLE});
    check("rst_rx_state", {30'b0, dut.rx_state}, {30'b0, RX_IDLE});
  endtask

  initial begin
    // Reset
    step();
    step();
    check_reset_outputs();
    rst = 1'b1;
    step();

    // TX: 3-word message, ack always high
    msg[0] = 14'h0AA; msg[1] = 14'h0BB; msg[2] = 14'h0CC;
    send_msg(3'd3, 3'd1, 3);
    check("tx_req_cycles", req_cycles, 32'd4);

    // TX: same message with 5-cycle ack stall per flit
    ack_mode = 1;
    send_msg(3'd3, 3'd1, 3);
    ack_mode = 0;
    step();

    // TX: single-word message (head then tail), random payload
    msg[0] = 14'($urandom_range(0, 16383));
    send_msg(3'd0, 3'd7, 1);
    check("tx_1word_req_cycles", req_cycles, 32'd2);

    // RX: packet for this node
    err_cnt = 0;
    exp_q.push_back({3'd0, 3'd0, 1'b0, 14'h123});
    exp_q.push_back({3'd0, 3'd0, 1'b1, 14'h456});
    put_flit(build_head(3'd2, 3'd1, 3'd0, 3'd0));
    put_flit({2'b00, 14'h123});
    put_flit({2'b10, 14'h456});
    drain_rx();
    check("rx_good_no_err", err_cnt, 32'd0);

    // RX: packet for another node is dropped
    err_cnt = 0;
    put_flit(build_head(3'd5, 3'd5, 3'd1, 3'd1));
    put_flit({2'b00, 14'h055});
    put_flit({2'b10, 14'h066});
    step();
    step();
    check("rx_drop_err_once", err_cnt, 32'd1);
    check("rx_drop_idle", {30'b0, dut.rx_state}, {30'b0, RX_IDLE});
    check("rx_drop_no_word", {31'b0, rx_valid}, 32'd0);

    // RX: stray body flit in IDLE
    err_cnt = 0;
    put_flit({2'b00, 14'h077});
    step();
    step();
    check("rx_stray_err", err_cnt, 32'd1);

    // RX: head inside a packet aborts it, earlier words survive
    err_cnt = 0;
    exp_q.push_back({3'd0, 3'd0, 1'b0, 14'h011});
    put_flit(build_head(3'd2, 3'd1, 3'd0, 3'd0));
    put_flit({2'b00, 14'h011});
    put_flit(build_head(3'd2, 3'd1, 3'd6, 3'd6));
    put_flit({2'b10, 14'h022});
    drain_rx();
    check("rx_abort_err", err_cnt, 32'd1);
    check("rx_abort_idle", {30'b0, dut.rx_state}, {30'b0, RX_IDLE});

    // RX: FIFO backpressure with rx_ready low
    rx_ready = 1'b0;
    put_flit(build_head(3'd2, 3'd1, 3'd3, 3'd4));
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({3'd3, 3'd4, 1'b0, 14'(k * 16 + 1)});
      put_flit({2'b00, 14'(k * 16 + 1)});
    end
    net_reqin  = 1'b1;
    net_datain = {2'b00, 14'h051};
    for (int k = 0; k < 3; k++) begin
      step();
      check("rx_ack_full", {31'b0, net_ackout}, 32'd0);
      check("rx_valid_full", {31'b0, rx_valid}, 32'd1);
    end
    rx_ready = 1'b1;
    exp_q.push_back({3'd3, 3'd4, 1'b0, 14'h051});
    put_flit({2'b00, 14'h051});
    exp_q.push_back({3'd3, 3'd4, 1'b0, 14'h061});
    put_flit({2'b00, 14'h061});
    exp_q.push_back({3'd3, 3'd4, 1'b1, 14'h071});
    put_flit({2'b10, 14'h071});
    drain_rx();

    // Reset mid-RX (word left in FIFO) and mid-TX (in BODY with req high)
    rx_ready = 1'b0;
    put_flit(build_head(3'd2, 3'd1, 3'd1, 3'd2));
    put_flit({2'b00, 14'h0EE});
    tx_q.push_back(build_head(3'd1, 3'd1, lx, ly));
    tx_q.push_back({2'b00, 14'h0AB});
    tx_dst_x = 3'd1;
    tx_dst_y = 3'd1;
    tx_valid = 1'b1;
    tx_data  = 14'h0AB;
    step();
    step();
    step();
    check("pre_rst_tx_body", {30'b0, dut.tx_state}, {30'b0, TX_BODY});
    rst      = 1'b0;
    tx_valid = 1'b0;
    step();
    check_reset_outputs();
    check("rst_tx_q_empty", tx_q.size(), 32'd0);
    exp_q.delete();
    rst      = 1'b1;
    rx_ready = 1'b1;
    step();

    // Clean traffic after reset
    msg[0] = 14'h0DE; msg[1] = 14'h0AD;
    send_msg(3'd4, 3'd2, 2);
    exp_q.push_back({3'd7, 3'd7, 1'b1, 14'h3FF});
    put_flit(build_head(3'd2, 3'd1, 3'd7, 3'd7));
    put_flit({2'b10, 14'h3FF});
    drain_rx();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
